idct1d_seq: RTL and testbench
=============================

// Module: idct1d_seq
// PURPOSE
//   8-point 1-D inverse DCT (orthonormal DCT-III), the inverse of the team's 8-point forward DCT.
//   Takes 8 signed coefficients X0..X7 in the same packing the forward DCT emits.
//   Returns 8 signed spatial samples x0..x7.
//   Sequential engine: 4 shared multipliers, even/odd symmetry, valid/ready on both sides.
//   Sits downstream of the forward DCT in the codec loop-back / reconstruction path.
// PARAMETERS
//   N     16  sample/coefficient width, signed two's complement
//   FRAC  12  fractional bits of the fixed-point cosine weights (unsigned Q0.FRAC magnitude + sign)
// PORTS
//   clk        in   1    clock, rising edge
//   reset      in   1    asynchronous, active-high reset
//   in_valid   in   1    data_in holds a coefficient vector
//   in_ready   out  1    engine can accept a vector (high only in IDLE)
//   data_in    in   8*N  {X0,X1,...,X7}; X0 in [8N-1 -: N]
//   out_valid  out  1    data_out holds a result
//   out_ready  in   1    downstream accepts data_out
//   data_out   out  8*N  {x0,x1,...,x7}; x0 in [8N-1 -: N]
//   busy       out  1    high in CALC or ROUND
// BEHAVIOUR
//   Math: x[n] = sum_k c(k)*cos((2n+1)k*pi/16)*X[k], with c(0)=1/(2*sqrt2) and c(k>0)=1/2.
//   Weights W[n][k] = round(c(k)*cos(...)*2^FRAC), held as a constant table for n=0..3.
//   Example entries (FRAC=12): W[n][0]=1448; W[0][1]=2009.
//   Symmetry: W[7-n][k] = (-1)^k * W[n][k].
//   Reset (async): state=IDLE, in_ready=1, out_valid=0, busy=0, data_out=0, accumulators=0, k=0.
//   FSM: IDLE -> CALC -> ROUND -> DONE -> IDLE.
//   IDLE: in_ready=1. On an edge with in_valid=1:
//     - latch data_in, clear acc[0..7], set k=0, go to CALC.
//   CALC: 8 cycles, k=0..7, one coefficient per edge.
//     - p_n = Xk*W[n][k] for n=0..3.
//     - acc[n] += p_n.
//     - acc[7-n] += p_n if k is even; acc[7-n] -= p_n if k is odd.
//     - After the k=7 edge, go to ROUND.
//   Widths: products N+FRAC+1 bits signed; accumulators N+FRAC+4 bits signed; no overflow possible.
//   ROUND (1 edge): each output is computed and registered into data_out, then go to DONE.
//     - y = (acc + 2^(FRAC-1)) >>> FRAC, arithmetic shift.
//     - Saturate y to [-2^(N-1), 2^(N-1)-1].
//     - Set out_valid=1.
//   DONE: out_valid=1; data_out stable until accepted.
//     - On an edge with out_ready=1: out_valid=0, go to IDLE.
//     - in_ready rises the cycle after that edge; no same-cycle accept in DONE.
//   Latency: accept edge E0, CALC edges E1..E8, ROUND edge E9, so out_valid is high after E9.
//   Minimum spacing between accepts is 11 cycles.
//   in_valid is ignored outside IDLE; data_in may change freely after the accept edge.
//   out_ready is ignored outside DONE.
//   Reset asserted mid-CALC/ROUND/DONE aborts the vector; no partial result is ever presented.
//   data_out holds its last value through IDLE/CALC; it is only meaningful while out_valid=1.
// TESTING
//   1 DC: X0=1000, rest 0 -> all x0..x7 = 354; out_valid high exactly 9 edges after accept.
//   2 AC1: X1=1000, rest 0 -> x0=490, x7=-490; x1..x6 match the float model within +-1 LSB.
//   3 Saturation: all Xk=32767 (N=16) -> x0=32767.
//     Every output that overflows clamps to 32767 or -32768, never wraps.
//   4 Backpressure: hold out_ready=0 for 20 cycles after out_valid.
//     -> data_out stable; in_ready=0; a new in_valid is ignored.
//     Then raise out_ready -> IDLE, and the next vector is accepted.
//   5 Round trip: random N=16 vectors through the forward DCT then idct1d_seq.
//     -> each reconstructed sample within +-2 LSB of its input; 1000 vectors.
//   6 Reset at CALC cycle 4 -> out_valid=0, data_out=0, in_ready=1 after release.
//     The next vector produces the correct result.

Source files
------------

// File: rtl/idct1d_seq.sv
// idct1d_seq: 8-point 1-D inverse DCT (orthonormal DCT-III) computed sequentially.
// Each cycle one coefficient Xk is multiplied by the four weights W[0..3][k]. Each
// product is added into acc[n]. It is also added into or subtracted from acc[7-n],
// using the symmetry W[7-n][k] = (-1)^k * W[n][k].
// The engine handles one vector at a time: accept, 8 CALC edges, 1 ROUND edge, then
// it holds the result until downstream accepts it.
module idct1d_seq #(
  parameter int N    = 16,
  parameter int FRAC = 12
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [8*N-1:0] data_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [8*N-1:0] data_out,
  output logic           busy
);

  localparam int PW = N + FRAC + 1;  // product width
  localparam int AW = N + FRAC + 4;  // accumulator width

  localparam logic signed [AW-1:0] HALF = AW'(1) <<< (FRAC - 1);
  localparam logic signed [AW-1:0] MAXV = AW'(2 ** (N - 1) - 1);
  localparam logic signed [AW-1:0] MINV = -MAXV - AW'(1);

  // Cosine weights for rows n=0..3 at 12 fractional bits. Rows 4..7 follow by symmetry.
  localparam int W12 [4][8] = '{
    '{1448,  2009,  1892,  1703,  1448,  1138,   784,   400},
    '{1448,  1703,   784,  -400, -1448, -2009, -1892, -1138},
    '{1448,  1138,  -784, -2009, -1448,   400,  1892,  1703},
    '{1448,   400, -1892, -1138,  1448,  1703,  -784, -2009}
  };

  typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;

  // Rescales the 12-bit table to FRAC bits, rounding half away from zero.
  // When FRAC is 12 this returns the table entry unchanged.
  function automatic logic signed [FRAC:0] weight(input int n, input logic [2:0] k);
    int w;
    int s;
    w = W12[n][k];
    s = (w * (1 << FRAC) + ((w < 0) ? -2048 : 2048)) / 4096;
    return (FRAC + 1)'(s);
  endfunction

  // Rounds half up, shifts back to integer scale, and clamps to the N-bit signed range.
  function automatic logic signed [N-1:0] sat_round(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] t;
    t = (a + HALF) >>> FRAC;
    if (t > MAXV)      return MAXV[N-1:0];
    else if (t < MINV) return MINV[N-1:0];
    else               return t[N-1:0];
  endfunction

  state_t               state_q, state_d;
  logic [2:0]           k_q, k_d;
  logic [8*N-1:0]       coef_q, coef_d;
  logic signed [AW-1:0] acc_q [8];
  logic signed [AW-1:0] acc_d [8];
  logic [8*N-1:0]       dout_q, dout_d;

  logic signed [N-1:0]  x_sel;
  logic signed [PW-1:0] prod  [4];
  logic signed [N-1:0]  y_rnd [8];

  // The current coefficient Xk, where X0 is in the most significant slot.
  assign x_sel = signed'(coef_q[(7 - int'(k_q))*N +: N]);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_mul
      logic signed [FRAC:0] w_sel;
      assign w_sel    = weight(gi, k_q);
      assign prod[gi] = PW'(x_sel) * PW'(w_sel);
    end
    for (gi = 0; gi < 8; gi++) begin : g_rnd
      assign y_rnd[gi] = sat_round(acc_q[gi]);
    end
  endgenerate

  // State and datapath registers; reset clears every register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      coef_q  <= '0;
      dout_q  <= '0;
      for (int i = 0; i < 8; i++) acc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      coef_q  <= coef_d;
      dout_q  <= dout_d;
      for (int i = 0; i < 8; i++) acc_q[i] <= acc_d[i];
    end
  end

  // Next-state logic, datapath updates and handshake outputs.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    coef_d    = coef_q;
    acc_d     = acc_q;
    dout_d    = dout_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          coef_d = data_in;
          for (int i = 0; i < 8; i++) acc_d[i] = '0;
          k_d     = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
          acc_d[i] = acc_q[i] + AW'(prod[i]);
          if (k_q[0]) acc_d[7-i] = acc_q[7-i] - AW'(prod[i]);
          else        acc_d[7-i] = acc_q[7-i] + AW'(prod[i]);
        end
        k_d = k_q + 3'd1;
        if (k_q == 3'd7) state_d = ROUND;
      end
      ROUND: begin
        busy = 1'b1;
        for (int i = 0; i < 8; i++) dout_d[(7-i)*N +: N] = y_rnd[i];
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_out = dout_q;

endmodule

// File: tb/tb_idct1d_seq.sv
// Testbench for idct1d_seq. The expected values come from a reference model.
// The model builds the weights from the cosine formula, accumulates over all
// 8x8 terms without using symmetry, then rounds and saturates.
module tb_idct1d_seq;

  localparam int N = 16;
  localparam int FRAC = 12;
  localparam real PI = 3.14159265358979323846;

  typedef int vec_t [8];

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [8*N-1:0] data_in = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [8*N-1:0] data_out;
  logic           busy;

  int n_cmp = 0;
  int n_bad = 0;
  int n_txn = 0;
  int w_ref [8][8];

  idct1d_seq #(.N(N), .FRAC(FRAC)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time exceeded bound");
    $fatal(1, "watchdog");
  end

  function automatic int round_r(input real r);
    if (r >= 0.0) return $rtoi(r + 0.5);
    else          return -$rtoi(-r + 0.5);
  endfunction

  function automatic real ck(input int k);
    return (k == 0) ? 1.0 / (2.0 * $sqrt(2.0)) : 0.5;
  endfunction

  function automatic real cosv(input int n, input int k);
    return $cos(real'((2*n + 1) * k) * PI / 16.0);
  endfunction

  function automatic void build_weights();
    for (int n = 0; n < 8; n++)
      for (int k = 0; k < 8; k++)
        w_ref[n][k] = round_r(ck(k) * cosv(n, k) * real'(1 << FRAC));
  endfunction

  function automatic void model(input vec_t X, output vec_t y);
    for (int n = 0; n < 8; n++) begin
      longint acc;
      longint t;
      acc = 0;
      for (int k = 0; k < 8; k++) acc += longint'(X[k]) * longint'(w_ref[n][k]);
      t = (acc + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
      if (t > 32767) t = 32767;
      if (t < -32768) t = -32768;
      y[n] = int'(t);
    end
  endfunction

  function automatic logic [8*N-1:0] pack(input vec_t X);
    logic [8*N-1:0] p;
    p = '0;
    for (int k = 0; k < 8; k++) p[(7-k)*N +: N] = N'(X[k]);
    return p;
  endfunction

  function automatic void unpack(input logic [8*N-1:0] d, output vec_t y);
    for (int k = 0; k < 8; k++) y[k] = int'($signed(d[(7-k)*N +: N]));
  endfunction

  // Sends one vector and waits for the result. Call this at a negedge with the
  // engine idle. The task then completes the output handshake.
  task automatic run_vector(input vec_t X, output vec_t y, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL accept_wait: in_ready=%0b required 1", in_ready);
    end
    in_valid = 1'b1;
    data_in  = pack(X);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    data_in  = {$urandom, $urandom, $urandom, $urandom};
    lat = 0;
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL out_valid_timeout: out_valid=%0b required 1 within 40 cycles", out_valid);
    end
    unpack(data_out, y);
    n_txn++;
    $display("txn %0d: X0=%0d X1=%0d -> x0=%0d x7=%0d lat=%0d", n_txn, X[0], X[1], y[0], y[7], lat);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_cmp++;
    if (data_out !== '0) begin n_bad++; $display("FAIL reset_data_out: got %h want 0", data_out); end
  endtask

  task automatic test_dc();
    vec_t X, y;
    int lat;
    X = '{1000, 0, 0, 0, 0, 0, 0, 0};
    run_vector(X, y, lat);
    n_cmp++;
    if (lat !== 9) begin n_bad++; $display("FAIL dc_latency: got %0d want 9", lat); end
    for (int n = 0; n < 8; n++) begin
      n_cmp++;
      if (y[n] !== 354) begin n_bad++; $display("FAIL dc_x%0d: got %0d want 354", n, y[n]); end
    end
  endtask

  task automatic test_ac1();
    vec_t X, y;
    int lat;
    X = '{0, 1000, 0, 0, 0, 0, 0, 0};
    run_vector(X, y, lat);
    n_cmp++;
    if (y[0] !== 490) begin n_bad++; $display("FAIL ac1_x0: got %0d want 490", y[0]); end
    n_cmp++;
    if (y[7] !== -490) begin n_bad++; $display("FAIL ac1_x7: got %0d want -490", y[7]); end
    for (int n = 1; n < 7; n++) begin
      real xf;
      xf = 0.5 * cosv(n, 1) * 1000.0;
      n_cmp++;
      if (real'(y[n]) - xf > 1.0 || xf - real'(y[n]) > 1.0) begin
        n_bad++;
        $display("FAIL ac1_x%0d: got %0d want %f +-1", n, y[n], xf);
      end
    end
  endtask

  task automatic test_saturation();
    vec_t X, y, e;
    int lat;
    for (int s = 0; s < 2; s++) begin
      int v;
      v = (s == 0) ? 32767 : -32768;
      X = '{v, v, v, v, v, v, v, v};
      model(X, e);
      run_vector(X, y, lat);
      n_cmp++;
      if (y[0] !== v) begin n_bad++; $display("FAIL sat_x0: got %0d want %0d", y[0], v); end
      for (int n = 0; n < 8; n++) begin
        n_cmp++;
        if (y[n] !== e[n]) begin n_bad++; $display("FAIL sat_x%0d: got %0d want %0d", n, y[n], e[n]); end
      end
    end
  endtask

  task automatic test_random();
    vec_t X, y, e;
    int lat;
    for (int v = 0; v < 200; v++) begin
      for (int k = 0; k < 8; k++) X[k] = int'($signed(16'($urandom)));
      model(X, e);
      run_vector(X, y, lat);
      for (int n = 0; n < 8; n++) begin
        n_cmp++;
        if (y[n] !== e[n]) begin n_bad++; $display("FAIL rand_v%0d_x%0d: got %0d want %0d", v, n, y[n], e[n]); end
      end
    end
  endtask

  task automatic test_backpressure();
    vec_t A, B, y, e;
    logic [8*N-1:0] snap;
    int lat;
    for (int k = 0; k < 8; k++) begin
      A[k] = int'($signed(16'($urandom)));
      B[k] = int'($signed(16'($urandom)));
    end
    in_valid = 1'b1;
    data_in  = pack(A);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    model(A, e);
    unpack(data_out, y);
    for (int n = 0; n < 8; n++) begin
      n_cmp++;
      if (y[n] !== e[n]) begin n_bad++; $display("FAIL bp_a_x%0d: got %0d want %0d", n, y[n], e[n]); end
    end
    snap     = data_out;
    in_valid = 1'b1;
    data_in  = pack(B);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_cmp++;
      if (data_out !== snap || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL bp_hold_c%0d: data_out=%h in_ready=%0b out_valid=%0b want %h 0 1",
                 c, data_out, in_ready, out_valid, snap);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_release: in_ready=%0b out_valid=%0b want 1 0", in_ready, out_valid);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    n_cmp++;
    if (lat !== 9) begin n_bad++; $display("FAIL bp_b_latency: got %0d want 9", lat); end
    model(B, e);
    unpack(data_out, y);
    for (int n = 0; n < 8; n++) begin
      n_cmp++;
      if (y[n] !== e[n]) begin n_bad++; $display("FAIL bp_b_x%0d: got %0d want %0d", n, y[n], e[n]); end
    end
    n_txn++;
    $display("txn %0d: backpressure pair done", n_txn);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    vec_t A, B, y, e;
    int lat;
    A = '{1234, -567, 890, -12, 345, -678, 901, -234};
    B = '{-3000, 2500, -2000, 1500, -1000, 500, -250, 125};
    in_valid = 1'b1;
    data_in  = pack(A);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy: got %0b want 1", busy); end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_out_valid: got %0b want 0", out_valid); end
    n_cmp++;
    if (data_out !== '0) begin n_bad++; $display("FAIL mid_data_out: got %h want 0", data_out); end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_in_ready: got %0b want 1", in_ready); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    model(B, e);
    run_vector(B, y, lat);
    for (int n = 0; n < 8; n++) begin
      n_cmp++;
      if (y[n] !== e[n]) begin n_bad++; $display("FAIL mid_next_x%0d: got %0d want %0d", n, y[n], e[n]); end
    end
  endtask

  task automatic test_round_trip();
    vec_t xs, X, y;
    int lat;
    for (int v = 0; v < 1000; v++) begin
      for (int n = 0; n < 8; n++) xs[n] = int'($urandom_range(0, 4095)) - 2048;
      for (int k = 0; k < 8; k++) begin
        real s;
        s = 0.0;
        for (int n = 0; n < 8; n++) s += real'(xs[n]) * cosv(n, k);
        X[k] = round_r(ck(k) * s);
      end
      run_vector(X, y, lat);
      for (int n = 0; n < 8; n++) begin
        n_cmp++;
        if (y[n] - xs[n] > 2 || xs[n] - y[n] > 2) begin
          n_bad++;
          $display("FAIL rt_v%0d_x%0d: got %0d want %0d +-2", v, n, y[n], xs[n]);
        end
      end
    end
  endtask

  initial begin
    build_weights();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_dc();
    test_ac1();
    test_saturation();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_round_trip();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
